// File: rtl/mult_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM states and Booth digit encodings.
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } mult_state_e;

  typedef enum logic [1:0] {
    SelZero = 2'd0,
    SelA    = 2'd1,
    Sel2A   = 2'd2
  } booth_sel_e;

  // A Booth digit is a magnitude select plus a negate flag.
  typedef struct packed {
    booth_sel_e sel;
    logic       neg;
  } booth_digit_t;

  localparam booth_digit_t DigZero  = '{sel: SelZero, neg: 1'b0};
  localparam booth_digit_t DigPosA  = '{sel: SelA,    neg: 1'b0};
  localparam booth_digit_t DigPos2A = '{sel: Sel2A,   neg: 1'b0};
  localparam booth_digit_t DigNegA  = '{sel: SelA,    neg: 1'b1};
  localparam booth_digit_t DigNeg2A = '{sel: Sel2A,   neg: 1'b1};

endpackage

// File: rtl/booth4_recoder.sv
// Radix-4 Booth recoder: maps a multiplier bit triple (with helper bit) to select/negate controls.
module booth4_recoder
  import mult_pkg::*;
(
  input  logic [2:0] i_triple,
  output booth_sel_e o_sel,
  output logic       o_neg
);

  booth_digit_t w_digit;

  always_comb begin
    w_digit = DigZero;
    case (i_triple)
      3'b001, 3'b010: w_digit = DigPosA;
      3'b011:         w_digit = DigPos2A;
      3'b100:         w_digit = DigNeg2A;
      3'b101, 3'b110: w_digit = DigNegA;
      default:        w_digit = DigZero;
    endcase
  end

  assign o_sel = w_digit.sel;
  assign o_neg = w_digit.neg;

endmodule

// File: rtl/radix4_multiplier.sv
// Sequential radix-4 Booth multiplier: one Booth digit per cycle, signed or unsigned operands,
// full 2*WIDTH product with low-half overflow flag.
module radix4_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               ctrl_MULT,
  input  logic               stop_MULT,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  output logic [2*WIDTH-1:0] mult_product,
  output logic [WIDTH-1:0]   mult_result,
  output logic               mult_exception,
  output logic               mult_busy,
  output logic               mult_ready
);

  localparam int unsigned EXT_W = WIDTH + 2;
  // Upper half carries two guard bits so +/-2A never overflows a partial sum.
  localparam int unsigned UP_W  = WIDTH + 4;
  localparam int unsigned ACC_W = UP_W + EXT_W + 1;
  localparam int unsigned ITER  = WIDTH / 2 + 1;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  mult_state_e        r_state, w_state_next;
  logic [EXT_W-1:0]   r_a;
  logic               r_signed;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic               r_exc;

  logic               w_start;
  logic               w_last;
  logic [EXT_W-1:0]   w_a_ext;
  logic [EXT_W-1:0]   w_b_ext;
  booth_sel_e         w_sel;
  logic               w_neg;
  logic [UP_W-1:0]    w_a_up;
  logic [UP_W-1:0]    w_mag;
  logic [UP_W-1:0]    w_upper_sum;
  logic [ACC_W-1:0]   w_acc_step;
  logic [2*WIDTH-1:0] w_final;
  logic [WIDTH:0]     w_hi_signed;
  logic               w_exc;

  assign w_start = ctrl_MULT & ~stop_MULT & (r_state != StRun);
  assign w_last  = (r_state == StRun) && (r_cnt == CNT_W'(ITER - 1));

  assign w_a_ext = signed_mode ? {{2{data_operandA[WIDTH-1]}}, data_operandA}
                               : {2'b00, data_operandA};
  assign w_b_ext = signed_mode ? {{2{data_operandB[WIDTH-1]}}, data_operandB}
                               : {2'b00, data_operandB};

  booth4_recoder u_recoder (
    .i_triple (r_acc[2:0]),
    .o_sel    (w_sel),
    .o_neg    (w_neg)
  );

  assign w_a_up = {{(UP_W - EXT_W){r_a[EXT_W-1]}}, r_a};

  always_comb begin
    w_mag = '0;
    case (w_sel)
      SelA:    w_mag = w_a_up;
      Sel2A:   w_mag = w_a_up << 1;
      default: w_mag = '0;
    endcase
  end

  // Negation as invert-plus-one folded into the single accumulator adder.
  assign w_upper_sum = r_acc[ACC_W-1 -: UP_W] + (w_mag ^ {UP_W{w_neg}})
                     + {{(UP_W - 1){1'b0}}, w_neg};
  assign w_acc_step  = {{2{w_upper_sum[UP_W-1]}}, w_upper_sum, r_acc[ACC_W-UP_W-1:2]};

  assign w_final     = w_acc_step[2*WIDTH:1];
  assign w_hi_signed = w_final[2*WIDTH-1:WIDTH-1];
  assign w_exc       = r_signed ? ~((&w_hi_signed) | ~(|w_hi_signed))
                                : |w_final[2*WIDTH-1:WIDTH];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = w_start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
    if (stop_MULT) w_state_next = StIdle;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_a       <= '0;
      r_signed  <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_exc     <= 1'b0;
    end else if (stop_MULT) begin
      r_a       <= '0;
      r_signed  <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_exc     <= 1'b0;
    end else if (w_start) begin
      r_a       <= w_a_ext;
      r_signed  <= signed_mode;
      r_acc     <= {{UP_W{1'b0}}, w_b_ext, 1'b0};
      r_cnt     <= '0;
      r_product <= '0;
      r_exc     <= 1'b0;
    end else if (r_state == StRun) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_product <= w_final;
        r_exc     <= w_exc;
      end
    end
  end

  assign mult_product   = r_product;
  assign mult_result    = r_product[WIDTH-1:0];
  assign mult_exception = r_exc;
  assign mult_busy      = (r_state == StRun);
  assign mult_ready     = (r_state == StDone);

endmodule

// File: tb/tb_radix4_multiplier.sv
// Scoreboard bench: a WIDTH=32 instance for directed and random operations, and 32 WIDTH=8
// instances in lockstep that together sweep every operand pair in both modes.
module tb_radix4_multiplier;

  localparam int N8 = 32;

  typedef struct {
    logic [63:0] prod;
    logic        exc;
    int          start;
  } exp32_t;

  typedef struct {
    logic [15:0] prod;
    logic        exc;
    int          start;
  } exp8_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   done32 = 1'b0;
  bit   done8 = 1'b0;
  int   busy_len = 0;

  logic        clr_n, ctrl, stop, sm;
  logic [31:0] opa, opb;
  logic [63:0] prod;
  logic [31:0] res;
  logic        exc, busy, rdy;

  logic        clr8_n, ctrl8, sm8;
  logic [7:0]  a8  [N8];
  logic [7:0]  b8  [N8];
  logic [15:0] p8  [N8];
  logic [7:0]  r8  [N8];
  logic        e8  [N8];
  logic        bz8 [N8];
  logic        rd8 [N8];

  exp32_t q32[$];
  exp8_t  q8 [N8][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  radix4_multiplier #(.WIDTH(32)) u_dut32 (
    .clk            (clk),
    .clr_n          (clr_n),
    .ctrl_MULT      (ctrl),
    .stop_MULT      (stop),
    .signed_mode    (sm),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .mult_product   (prod),
    .mult_result    (res),
    .mult_exception (exc),
    .mult_busy      (busy),
    .mult_ready     (rdy)
  );

  for (genvar g = 0; g < N8; g++) begin : g_w8
    radix4_multiplier #(.WIDTH(8)) u_dut8 (
      .clk            (clk),
      .clr_n          (clr8_n),
      .ctrl_MULT      (ctrl8),
      .stop_MULT      (1'b0),
      .signed_mode    (sm8),
      .data_operandA  (a8[g]),
      .data_operandB  (b8[g]),
      .mult_product   (p8[g]),
      .mult_result    (r8[g]),
      .mult_exception (e8[g]),
      .mult_busy      (bz8[g]),
      .mult_ready     (rd8[g])
    );
  end

  // Reference: plain integer multiplication, overflow judged by representable range.
  function automatic exp32_t model32(input logic s, input logic [31:0] a, input logic [31:0] b,
                                     input int st);
    exp32_t      e;
    longint      p;
    logic [63:0] u;
    if (s) begin
      p      = longint'($signed(a)) * longint'($signed(b));
      e.prod = p;
      e.exc  = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else begin
      u      = {32'd0, a} * {32'd0, b};
      e.prod = u;
      e.exc  = (u > 64'h0000_0000_FFFF_FFFF);
    end
    e.start = st;
    return e;
  endfunction

  function automatic exp8_t model8(input logic s, input logic [7:0] a, input logic [7:0] b,
                                   input int st);
    exp8_t e;
    int    p;
    if (s) begin
      p     = int'($signed(a)) * int'($signed(b));
      e.exc = (p > 127) || (p < -128);
    end else begin
      p     = int'(a) * int'(b);
      e.exc = (p > 255);
    end
    e.prod  = 16'(p);
    e.start = st;
    return e;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom % 6)
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push_const(input logic [63:0] xp, input logic xe);
    q32.push_back('{prod: xp, exc: xe, start: cyc + 1});
  endtask

  task automatic push_model(input logic s, input logic [31:0] a, input logic [31:0] b);
    q32.push_back(model32(s, a, b, cyc + 1));
  endtask

  // Called at a falling edge; the start is sampled at the following rising edge.
  task automatic issue32(input logic s, input logic [31:0] a, input logic [31:0] b);
    ctrl = 1'b1;
    sm   = s;
    opa  = a;
    opb  = b;
    @(negedge clk);
    ctrl = 1'b0;
  endtask

  task automatic wait_ready32();
    int n = 0;
    while (rdy !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rdy !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL w32 ready timeout: ready=%b after 40 cycles, want 1", rdy);
    end
  endtask

  task automatic wait_ready8();
    int n = 0;
    while (rd8[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rd8[0] !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL w8 ready timeout: ready=%b after 20 cycles, want 1", rd8[0]);
    end
  endtask

  task automatic run_const(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] xp, input logic xe);
    push_const(xp, xe);
    issue32(s, a, b);
    wait_ready32();
    @(negedge clk);
  endtask

  task automatic drive32();
    logic        s;
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;

    run_const(1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run_const(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
    repeat (3) @(negedge clk);
    check("product held in idle", prod, 64'h4000_0000_0000_0000);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop clears product", prod, 64'd0);
    check("stop clears exception", 64'(exc), 64'd0);
    run_const(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    run_const(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);

    // Abort on the 5th RUN cycle; the aborted operation has no scoreboard entry.
    issue32(1'b0, 32'd12345, 32'd678);
    repeat (4) @(negedge clk);
    stop = 1'b1;
    ctrl = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort ready", 64'(rdy), 64'd0);
    check("abort product", prod, 64'd0);
    @(negedge clk);
    stop = 1'b0;
    ctrl = 1'b0;
    repeat (25) @(negedge clk);
    check("abort then start stays idle", 64'(busy), 64'd0);
    run_const(1'b0, 32'd6, 32'd7, 64'd42, 1'b0);

    // Starts during RUN are ignored; a start in the ready cycle is accepted.
    push_model(1'b1, 32'h0000_1234, 32'hFFFF_FFFB);
    issue32(1'b1, 32'h0000_1234, 32'hFFFF_FFFB);
    @(negedge clk);
    ctrl = 1'b1;
    sm   = 1'b0;
    opa  = 32'd9;
    opb  = 32'd9;
    repeat (3) @(negedge clk);
    ctrl = 1'b0;
    wait_ready32();
    push_model(1'b0, 32'd100000, 32'd300000);
    issue32(1'b0, 32'd100000, 32'd300000);
    wait_ready32();
    @(negedge clk);

    // Asynchronous reset mid-operation.
    issue32(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (3) @(negedge clk);
    check("busy before reset", 64'(busy), 64'd1);
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset ready", 64'(rdy), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    repeat (25) @(negedge clk);
    check("reset then idle", 64'(busy), 64'd0);

    // Asynchronous reset while a result with exception is held.
    run_const(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    check("reset product", prod, 64'd0);
    check("reset result", 64'(res), 64'd0);
    check("reset exception", 64'(exc), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    push_model(1'b1, 32'hFFFF_FF00, 32'd1000);
    issue32(1'b1, 32'hFFFF_FF00, 32'd1000);
    wait_ready32();
    @(negedge clk);

    // Random operations, mixing back-to-back starts with idle gaps.
    s = 1'($urandom % 2);
    a = pick32();
    b = pick32();
    push_model(s, a, b);
    issue32(s, a, b);
    for (int i = 0; i < 150; i++) begin
      wait_ready32();
      if ($urandom % 3 != 0) begin
        @(negedge clk);
        repeat ($urandom % 3) @(negedge clk);
      end
      s = 1'($urandom % 2);
      a = pick32();
      b = pick32();
      push_model(s, a, b);
      issue32(s, a, b);
    end
    wait_ready32();
    @(negedge clk);
    done32 = 1'b1;
  endtask

  task automatic drive8();
    repeat (2) @(negedge clk);
    clr8_n = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int j = 0; j < 8; j++) begin
        for (int b = 0; b < 256; b++) begin
          ctrl8 = 1'b1;
          sm8   = m[0];
          for (int g = 0; g < N8; g++) begin
            a8[g] = {g[4:0], j[2:0]};
            b8[g] = b[7:0];
            q8[g].push_back(model8(sm8, a8[g], b8[g], cyc + 1));
          end
          @(negedge clk);
          ctrl8 = 1'b0;
          wait_ready8();
        end
      end
    end
    @(negedge clk);
    done8 = 1'b1;
  endtask

  task automatic monitor();
    exp32_t e;
    exp8_t  f;
    while (!(done32 && done8)) begin
      @(negedge clk);
      if (cyc > 90000) begin
        checks++;
        failures++;
        $display("FAIL watchdog: cycle %0d reached, want completion", cyc);
        break;
      end
      if (rdy === 1'b1) begin
        if (q32.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL w32 unexpected ready: ready=1 with no operation pending, want 0");
        end else begin
          e = q32.pop_front();
          check("w32 product", prod, e.prod);
          check("w32 result", 64'(res), 64'(e.prod[31:0]));
          check("w32 exception", 64'(exc), 64'(e.exc));
          check("w32 latency", 64'(cyc - e.start), 64'd17);
          check("w32 busy cycles", 64'(busy_len), 64'd17);
        end
      end
      if (busy === 1'b1) check("w32 exception while busy", 64'(exc), 64'd0);
      busy_len = (busy === 1'b1) ? busy_len + 1 : 0;
      for (int g = 0; g < N8; g++) begin
        if (rd8[g] === 1'b1) begin
          if (q8[g].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL w8 unexpected ready: instance %0d ready=1, want 0", g);
          end else begin
            f = q8[g].pop_front();
            check("w8 product", 64'(p8[g]), 64'(f.prod));
            check("w8 result", 64'(r8[g]), 64'(f.prod[7:0]));
            check("w8 exception", 64'(e8[g]), 64'(f.exc));
            check("w8 latency", 64'(cyc - f.start), 64'd5);
          end
        end
      end
    end
  endtask

  initial begin
    clr_n  = 1'b0;
    ctrl   = 1'b0;
    stop   = 1'b0;
    sm     = 1'b0;
    opa    = '0;
    opb    = '0;
    clr8_n = 1'b0;
    ctrl8  = 1'b0;
    sm8    = 1'b0;
    for (int g = 0; g < N8; g++) begin
      a8[g] = '0;
      b8[g] = '0;
    end
    #2;
    check("initial product", prod, 64'd0);
    check("initial result", 64'(res), 64'd0);
    check("initial exception", 64'(exc), 64'd0);
    check("initial busy", 64'(busy), 64'd0);
    check("initial ready", 64'(rdy), 64'd0);
    check("initial w8 product", 64'(p8[0]), 64'd0);
    fork
      drive32();
      drive8();
      monitor();
    join
    check("w32 pending at end", 64'(q32.size()), 64'd0);
    for (int g = 0; g < N8; g++) check("w8 pending at end", 64'(q8[g].size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
